// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter feeding one registered nibble parity checker; results return over valid/ready.
// Optional saturating parity-error counter output err_cnt is enabled by defining PEC_ERR_COUNT_EN.
module parity_check_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0,
    localparam int IDW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_pec,
    input  logic                      rsp_ready,
    output logic                      busy
`ifdef PEC_ERR_COUNT_EN
   ,output logic [7:0]                err_cnt
`endif
);

    localparam int unsigned NR      = NUM_REQ;
    localparam logic        ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              pec_q, pec_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_id;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NR) idx = idx - NR;
            cand = IDW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        int unsigned nxt;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        word_d    = word_q;
        pec_d     = pec_q;
        req_ready = '0;
        nxt       = 0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    word_d   = req_data[32'(grant_id)*DATA_W +: DATA_W];
                    id_d     = grant_id;
                    nxt      = 32'(grant_id) + 1;
                    if (nxt >= NR) nxt = 0;
                    rr_ptr_d = IDW'(nxt);
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                pec_d   = (^word_q) ^ ODD_BIT;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // No accept strobe may escape while reset is being applied.
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            word_q   <= '0;
            pec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            word_q   <= word_d;
            pec_q    <= pec_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_pec   = pec_q;
    assign busy      = (state_q != IDLE);

`ifdef PEC_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (rsp_valid && rsp_ready && pec_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Scoreboard bench: random requesters and backpressure, expected responses queued at grant time.
// Also exercises an ODD_PARITY=1, NUM_REQ=2 instance with directed words.
module tb_parity_check_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int ODD = 0;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic           rsp_pec;
    logic           rsp_ready;
    logic           busy;
`ifdef PEC_ERR_COUNT_EN
    logic [7:0]     err_cnt;
    logic [7:0]     o_err_cnt;
`endif

    logic [1:0]     o_valid;
    logic [7:0]     o_data;
    logic [1:0]     o_ready;
    logic           o_rsp_valid;
    logic [0:0]     o_rsp_id;
    logic           o_rsp_pec;
    logic           o_rsp_ready;
    logic           o_busy;

    parity_check_arbiter #(.NUM_REQ(N), .DATA_W(W), .ODD_PARITY(ODD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_pec   (rsp_pec),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef PEC_ERR_COUNT_EN
       ,.err_cnt   (err_cnt)
`endif
    );

    parity_check_arbiter #(.NUM_REQ(2), .DATA_W(4), .ODD_PARITY(1)) dut_odd (
        .clk       (clk),
        .rst       (rst),
        .req_valid (o_valid),
        .req_data  (o_data),
        .req_ready (o_ready),
        .rsp_valid (o_rsp_valid),
        .rsp_id    (o_rsp_id),
        .rsp_pec   (o_rsp_pec),
        .rsp_ready (o_rsp_ready),
        .busy      (o_busy)
`ifdef PEC_ERR_COUNT_EN
       ,.err_cnt   (o_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int id;
        int pec;
    } rsp_t;

    rsp_t       exp_q[$];
    int         m_rr      = 0;
    int         gcyc      = 0;
    bit         pend      = 1'b0;
    bit         seen      = 1'b0;
    int         m_err     = 0;
    int         m_err_raw = 0;
    logic [N-1:0] acc_s   = '0;

    // Reference: round-robin from a model pointer, parity from a ones count.
    always @(negedge clk) begin
        int           w;
        rsp_t         e;
        logic [W-1:0] wd;
        cyc++;
        acc_s = req_ready & req_valid;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
`ifdef PEC_ERR_COUNT_EN
            chk("rst_err_cnt", 32'(err_cnt), 32'(0));
            m_err     = 0;
            m_err_raw = 0;
`endif
            exp_q.delete();
            m_rr = 0;
            pend = 1'b0;
            seen = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(pend));
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'(1));
`ifdef PEC_ERR_COUNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
            if (req_ready != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
                end
                chk("grant_while_busy", 32'(busy), 32'(0));
                chk("grant_onehot", 32'(req_ready), (w < 0) ? 32'(0) : 32'(1 << w));
                if (w >= 0) begin
                    wd    = req_data[w*W +: W];
                    e.id  = w;
                    e.pec = (($countones(wd) % 2) != ODD) ? 1 : 0;
                    exp_q.push_back(e);
                    m_rr  = (w + 1) % N;
                end
                pend = 1'b1;
                seen = 1'b0;
                gcyc = cyc;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - gcyc), 32'(2));
                        seen = 1'b1;
                    end
                    chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    chk("rsp_pec", 32'(rsp_pec), 32'(exp_q[0].pec));
                    if (rsp_ready) begin
`ifdef PEC_ERR_COUNT_EN
                        if (exp_q[0].pec != 0) begin
                            m_err_raw++;
                            if (m_err < 255) m_err++;
                        end
`endif
                        void'(exp_q.pop_front());
                        pend = 1'b0;
                    end
                end
            end else if (pend && (cyc - gcyc) >= 2) begin
                chk("rsp_missing", 32'(rsp_valid), 32'(1));
            end
        end
    end

    bit drv_en = 1'b0;
    int stall  = 0;

    // Requesters hold valid/data until accepted; occasionally withdraw.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                for (int i = 0; i < N; i++) begin
                    if (acc_s[i] || !req_valid[i]) begin
                        if ($urandom_range(0, 3) != 0) begin
                            req_valid[i]       = 1'b1;
                            req_data[i*W +: W] = W'($urandom);
                        end else begin
                            req_valid[i] = 1'b0;
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
                if (stall > 0) begin
                    rsp_ready = 1'b0;
                    stall--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    task automatic odd_word(input int idx, input logic [3:0] d, input int exp_pec);
        bit got;
        got = 1'b0;
        o_data[idx*4 +: 4] = d;
        o_valid[idx]       = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ready[idx]) begin
                got = 1'b1;
                break;
            end
        end
        chk("odd_accept", 32'(got), 32'(1));
        @(posedge clk);
        #1;
        o_valid = '0;
        got     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("odd_rsp_valid", 32'(got), 32'(1));
        if (got) begin
            chk("odd_rsp_id", 32'(o_rsp_id), 32'(idx));
            chk("odd_rsp_pec", 32'(o_rsp_pec), 32'(exp_pec));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        rst         = 1'b1;
        req_valid   = '1;
        req_data    = 16'h8421;
        rsp_ready   = 1'b1;
        o_valid     = '0;
        o_data      = '0;
        o_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        drv_en = 1'b1;

        repeat (200) @(posedge clk);

        // Hold a response under backpressure.
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_resp", 32'(found), 32'(1));
        stall = 5;
        repeat (100) @(posedge clk);

        // Reset while a word sits in CHECK: it must vanish without a response.
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (busy && !rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_check", 32'(found), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (2500) @(posedge clk);

        odd_word(0, 4'b1000, 0);
        odd_word(1, 4'b1001, 1);
        odd_word(0, 4'b0111, 0);

`ifdef PEC_ERR_COUNT_EN
        @(negedge clk);
        chk("err_cnt_final", 32'(err_cnt), (m_err_raw >= 255) ? 32'(255) : 32'(m_err_raw));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
